// File: rtl/data_store_buffer_pkg.sv
// Shared definitions for the posted-store buffer: memory FSM states,
// transaction/entry layout and data_mem sign_mask field positions.
package data_store_buffer_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int ENTRY_W       = 68;

  // data_mem sign_mask layout: access size in [1:0], sign-extend control in [2]
  localparam int MASK_SIZE_LSB = 0;
  localparam int MASK_SIZE_MSB = 1;
  localparam int MASK_SIGN_BIT = 2;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } store_entry_t;

endpackage

// File: rtl/data_store_buffer_store_fifo.sv
// In-order store queue: DEPTH entries of {addr, data, mask} with head and
// head+1 peek ports so the drain FSM can chain stores without a bubble.
module store_fifo
  import data_store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_entry,
  output logic [ENTRY_W-1:0] head,
  output logic [ENTRY_W-1:0] head_next,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign head_next = mem_r[rd_ptr_r + PTR_ONE];

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-store buffer between the core memory stage and data_mem: stores are
// queued and drained in order; loads wait for an empty queue, then issue.
module data_store_buffer
  import data_store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  mem_state_e   state_r, state_n;
  store_entry_t txn_r, txn_src_s, cpu_entry_s, head_s, head_next_s;
  logic         txn_write_r, txn_write_n, load_txn_s;
  logic [31:0]  cpu_read_data_r;
  logic         rd_done_r;
  logic [CNT_W-1:0] count_s;
  logic         full_s, empty_s;
  logic         accept_s, load_go_s, complete_s, pop_s, more_stores_s;

  assign cpu_entry_s = '{addr: cpu_addr, data: cpu_write_data, mask: cpu_sign_mask};
  assign accept_s    = cpu_memwrite & ~full_s;
  assign load_go_s   = cpu_memread & ~cpu_memwrite & empty_s & ~rd_done_r & (state_r == MS_IDLE);
  assign complete_s  = (state_r == MS_WAIT) & ~mem_clk_stall;
  assign pop_s       = complete_s & txn_write_r;
  // After a pop the queue keeps work only if more than the retiring head remains
  assign more_stores_s = pop_s ? (count_s > CNT_W'(1'b1)) : ~empty_s;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_s),
    .pop        (pop_s),
    .push_entry (cpu_entry_s),
    .head       (head_s),
    .head_next  (head_next_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Memory FSM next state and transaction selection
  always_comb begin
    state_n     = state_r;
    load_txn_s  = 1'b0;
    txn_src_s   = head_s;
    txn_write_n = 1'b1;
    case (state_r)
      MS_IDLE: begin
        if (~mem_clk_stall && (~empty_s || accept_s)) begin
          state_n    = MS_REQ;
          load_txn_s = 1'b1;
          txn_src_s  = empty_s ? cpu_entry_s : head_s;
        end else if (~mem_clk_stall && load_go_s) begin
          state_n     = MS_REQ;
          load_txn_s  = 1'b1;
          txn_src_s   = cpu_entry_s;
          txn_write_n = 1'b0;
        end else begin
          state_n = MS_IDLE;
        end
      end
      MS_REQ: begin
        state_n = MS_WAIT;
      end
      MS_WAIT: begin
        if (complete_s && more_stores_s) begin
          state_n    = MS_REQ;
          load_txn_s = 1'b1;
          txn_src_s  = pop_s ? head_next_s : head_s;
        end else if (complete_s && accept_s) begin
          state_n    = MS_REQ;
          load_txn_s = 1'b1;
          txn_src_s  = cpu_entry_s;
        end else if (complete_s) begin
          state_n = MS_IDLE;
        end else begin
          state_n = MS_WAIT;
        end
      end
      default: begin
        state_n = MS_IDLE;
      end
    endcase
  end

  // FSM state, transaction register and load return path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= MS_IDLE;
      txn_r           <= '{addr: 32'h0, data: 32'h0, mask: 4'h0};
      txn_write_r     <= 1'b0;
      rd_done_r       <= 1'b0;
      cpu_read_data_r <= 32'h0;
    end else begin
      state_r   <= state_n;
      rd_done_r <= complete_s & ~txn_write_r;
      if (load_txn_s) begin
        txn_r       <= txn_src_s;
        txn_write_r <= txn_write_n;
      end
      if (complete_s && !txn_write_r) begin
        cpu_read_data_r <= mem_read_data;
      end
    end
  end

  assign cpu_read_data  = cpu_read_data_r;
  assign cpu_stall      = (cpu_memwrite & full_s) | (cpu_memread & ~rd_done_r);
  assign mem_addr       = txn_r.addr;
  assign mem_write_data = txn_r.data;
  assign mem_sign_mask  = txn_r.mask;
  assign mem_memwrite   = (state_r == MS_REQ) & txn_write_r;
  assign mem_memread    = (state_r == MS_REQ) & ~txn_write_r;

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer with a small data_mem model that
// holds clk_stall for two cycles after every request strobe.
module tb_data_store_buffer;
  import data_store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = 32'h0, cpu_write_data = 32'h0;
  logic        cpu_memwrite = 1'b0, cpu_memread = 1'b0;
  logic [3:0]  cpu_sign_mask = 4'h0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memwrite, mem_memread, mem_clk_stall;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mem_model [0:4095];
  logic [1:0]  busy = 2'd0;
  logic        hold_stall = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [7:0]  led = 8'h0;
  int          wr_cyc[$];
  logic [31:0] wr_data[$];
  int          rd_cyc[$];

  data_store_buffer dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data),
    .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_sign_mask(mem_sign_mask), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  assign mem_clk_stall = (busy != 2'd0) | hold_stall;
  assign mem_read_data = rdata;

  // data_mem model: request logging, byte/word writes, LED register at 0x2000
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) mem_model[12'h400] <= 32'h11223344;
    if (busy != 2'd0) busy <= busy - 2'd1;
    if (mem_memwrite || mem_memread) busy <= 2'd2;
    if (mem_memwrite) begin
      wr_cyc.push_back(cyc);
      wr_data.push_back(mem_write_data);
      if (mem_sign_mask[MASK_SIZE_MSB:MASK_SIZE_LSB] == 2'b00)
        mem_model[mem_addr[13:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
      else
        mem_model[mem_addr[13:2]] <= mem_write_data;
      if (mem_addr == 32'h2000) led <= mem_write_data[7:0];
    end
    if (mem_memread) begin
      rd_cyc.push_back(cyc);
      rdata <= mem_model[mem_addr[13:2]];
    end
  end

  task automatic test_reset;
    @(negedge clk);
    cpu_memread = 1'b1;
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL reset_stall_eq: got %b want 1", cpu_stall); end
    cpu_memread = 1'b0;
    #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall_idle: got %b want 0", cpu_stall); end
    total++; if ({mem_memwrite, mem_memread} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {mem_memwrite, mem_memread}); end
    total++; if ({mem_addr, mem_write_data, mem_sign_mask} !== 68'h0) begin bad++; $display("FAIL reset_fields: got %h want 0", {mem_addr, mem_write_data, mem_sign_mask}); end
    total++; if (cpu_read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", cpu_read_data); end
    total++; if (dut.count_s !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.count_s); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_store;
    int t0, n0;
    @(negedge clk);
    t0 = cyc; n0 = wr_cyc.size();
    cpu_memwrite = 1'b1; cpu_addr = 32'h1004; cpu_write_data = 32'hDEADBEEF; cpu_sign_mask = 4'b0100;
    #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL single_stall: got %b want 0", cpu_stall); end
    @(negedge clk);
    cpu_memwrite = 1'b0;
    #1;
    total++; if (mem_memwrite !== 1'b1) begin bad++; $display("FAIL single_strobe_c1: got %b want 1", mem_memwrite); end
    total++; if ({mem_addr, mem_write_data, mem_sign_mask} !== {32'h1004, 32'hDEADBEEF, 4'b0100}) begin
      bad++; $display("FAIL single_fields: got %h %h %b want 1004 deadbeef 0100", mem_addr, mem_write_data, mem_sign_mask); end
    @(negedge clk); #1;
    total++; if (mem_memwrite !== 1'b0) begin bad++; $display("FAIL single_strobe_c2: got %b want 0", mem_memwrite); end
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (dut.count_s !== 3'd1) begin bad++; $display("FAIL single_count_c4: got %0d want 1", dut.count_s); end
    @(negedge clk); #1;
    total++; if (dut.count_s !== 3'd0) begin bad++; $display("FAIL single_count_c5: got %0d want 0", dut.count_s); end
    total++; if (wr_cyc.size() !== n0 + 1) begin bad++; $display("FAIL single_nwrites: got %0d want %0d", wr_cyc.size(), n0 + 1); end
    else begin
      total++; if (wr_cyc[n0] !== t0 + 1) begin bad++; $display("FAIL single_wr_cycle: got %0d want %0d", wr_cyc[n0], t0 + 1); end
    end
  endtask

  task automatic test_back_to_back;
    int t0, n0, stalls, w;
    int acc[5];
    @(negedge clk);
    t0 = cyc; n0 = wr_cyc.size();
    for (int i = 0; i < 5; i++) begin
      cpu_memwrite = 1'b1; cpu_addr = 32'h1100 + 32'(4 * i); cpu_write_data = 32'(i + 1); cpu_sign_mask = 4'b0010;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < 20) begin @(negedge clk); #1; stalls++; end
      acc[i] = cyc;
      @(negedge clk);
    end
    cpu_memwrite = 1'b0;
    total++; if (acc[3] !== t0 + 3) begin bad++; $display("FAIL b2b_accept4: got %0d want %0d", acc[3], t0 + 3); end
    total++; if (acc[4] !== t0 + 5) begin bad++; $display("FAIL b2b_accept5: got %0d want %0d", acc[4], t0 + 5); end
    w = 0;
    while (wr_cyc.size() < n0 + 5 && w < 60) begin @(negedge clk); w++; end
    total++; if (wr_cyc.size() !== n0 + 5) begin bad++; $display("FAIL b2b_nwrites: got %0d want %0d", wr_cyc.size(), n0 + 5); end
    else begin
      for (int k = 0; k < 5; k++) begin
        total++; if (wr_data[n0 + k] !== 32'(k + 1)) begin bad++; $display("FAIL b2b_order: got %h want %h", wr_data[n0 + k], k + 1); end
        total++; if (wr_cyc[n0 + k] !== t0 + 1 + 4 * k) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", wr_cyc[n0 + k], t0 + 1 + 4 * k); end
      end
    end
    repeat (5) @(negedge clk);
    #1;
    total++; if (dut.count_s !== 3'd0) begin bad++; $display("FAIL b2b_drained: got %0d want 0", dut.count_s); end
  endtask

  task automatic test_store_then_load;
    int t0, nr0, nw0, w;
    @(negedge clk);
    t0 = cyc; nr0 = rd_cyc.size(); nw0 = wr_cyc.size();
    cpu_memwrite = 1'b1; cpu_addr = 32'h1001; cpu_write_data = 32'h000000AA; cpu_sign_mask = 4'b0000;
    @(negedge clk);
    cpu_memwrite = 1'b0; cpu_memread = 1'b1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0010;
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL stld_stall: got %b want 1", cpu_stall); end
    w = 0;
    while (cpu_stall && w < 40) begin @(negedge clk); #1; w++; end
    total++; if (cyc !== t0 + 10) begin bad++; $display("FAIL stld_release: got %0d want %0d", cyc, t0 + 10); end
    total++; if (cpu_read_data !== 32'h1122AA44) begin bad++; $display("FAIL stld_rdata: got %h want 1122aa44", cpu_read_data); end
    @(negedge clk);
    cpu_memread = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rd_cyc.size() !== nr0 + 1) begin bad++; $display("FAIL stld_nreads: got %0d want %0d", rd_cyc.size(), nr0 + 1); end
    else begin
      total++; if (rd_cyc[nr0] !== t0 + 6) begin bad++; $display("FAIL stld_rd_cycle: got %0d want %0d", rd_cyc[nr0], t0 + 6); end
    end
    total++; if (wr_cyc.size() !== nw0 + 1) begin bad++; $display("FAIL stld_nwrites: got %0d want %0d", wr_cyc.size(), nw0 + 1); end
  endtask

  task automatic test_load_empty;
    int t0, stalls;
    @(negedge clk);
    t0 = cyc;
    cpu_memread = 1'b1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0010;
    #1;
    stalls = 0;
    while (cpu_stall && stalls < 40) begin stalls++; @(negedge clk); #1; end
    total++; if (stalls !== 5) begin bad++; $display("FAIL ld_stall_len: got %0d want 5", stalls); end
    total++; if (cyc !== t0 + 5) begin bad++; $display("FAIL ld_valid_cycle: got %0d want %0d", cyc, t0 + 5); end
    total++; if (cpu_read_data !== 32'h1122AA44) begin bad++; $display("FAIL ld_rdata: got %h want 1122aa44", cpu_read_data); end
    @(negedge clk);
    cpu_memread = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n0, seen, t1;
    @(negedge clk);
    n0 = wr_cyc.size();
    for (int i = 0; i < 3; i++) begin
      cpu_memwrite = 1'b1; cpu_addr = 32'h1300 + 32'(4 * i); cpu_write_data = 32'h50 + 32'(i); cpu_sign_mask = 4'b0010;
      @(negedge clk);
    end
    cpu_memwrite = 1'b0;
    #1;
    total++; if (dut.state_r !== MS_WAIT || dut.count_s !== 3'd3) begin
      bad++; $display("FAIL rstmid_setup: got state %0d count %0d want 2 3", dut.state_r, dut.count_s); end
    n0 = wr_cyc.size();
    hold_stall = 1'b1; rst = 1'b1;
    #1;
    total++; if (dut.count_s !== 3'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", dut.count_s); end
    @(negedge clk);
    rst = 1'b0;
    cpu_memwrite = 1'b1; cpu_addr = 32'h1400; cpu_write_data = 32'h77; cpu_sign_mask = 4'b0010;
    @(negedge clk);
    cpu_memwrite = 1'b0;
    seen = 0;
    repeat (5) begin #1; if (mem_memwrite || mem_memread) seen++; @(negedge clk); end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_strobe: got %0d want 0", seen); end
    total++; if (dut.count_s !== 3'd1) begin bad++; $display("FAIL rstmid_queued: got %0d want 1", dut.count_s); end
    hold_stall = 1'b0;
    t1 = cyc;
    @(negedge clk); #1;
    total++; if (mem_memwrite !== 1'b1 || mem_write_data !== 32'h77) begin
      bad++; $display("FAIL rstmid_resume: got %b %h want 1 77 (cycle %0d from %0d)", mem_memwrite, mem_write_data, cyc, t1); end
    repeat (5) @(negedge clk);
    total++; if (wr_cyc.size() !== n0 + 1) begin bad++; $display("FAIL rstmid_nwrites: got %0d want %0d", wr_cyc.size(), n0 + 1); end
  endtask

  task automatic test_led;
    @(negedge clk);
    cpu_memwrite = 1'b1; cpu_addr = 32'h2000; cpu_write_data = 32'h000000A5; cpu_sign_mask = 4'b0010;
    @(negedge clk);
    cpu_memwrite = 1'b0;
    #1;
    total++; if (mem_memwrite !== 1'b1 || mem_addr !== 32'h2000 || mem_write_data !== 32'hA5) begin
      bad++; $display("FAIL led_fields: got %b %h %h want 1 2000 a5", mem_memwrite, mem_addr, mem_write_data); end
    repeat (6) @(negedge clk);
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL led_value: got %h want a5", led); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_store_then_load();
    test_load_empty();
    test_reset_mid();
    test_led();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
